// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM states and port-select encodings for the RAM arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RECOVER} state_t;
  localparam logic SEL_I = 1'b0;
  localparam logic SEL_D = 1'b1;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational tie-break between the instruction and data masters
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int D_PRIORITY = 1
) (
  input  logic i_req,
  input  logic d_req,
  input  logic rr_last,
  output logic grant_valid,
  output logic grant_sel
);
  assign grant_valid = i_req | d_req;
  assign grant_sel = (i_req & d_req) ? ((D_PRIORITY != 0) ? SEL_D : ~rr_last) : d_req;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master arbiter for a single-port multi-cycle RAM with an access watchdog
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16,
  parameter int D_PRIORITY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [DATA_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_ack,
  output logic                  i_err,
  output logic                  i_stall,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [DATA_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ack,
  output logic                  d_err,
  output logic                  d_stall,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  input  logic                  ram_ack
);
  localparam int CW = $clog2(TIMEOUT);
  state_t state_q, state_d;
  logic sel_q, sel_d, rr_last_q, rr_last_d, we_q, we_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d, din_q, din_d, rdata;
  logic [CW-1:0] cnt_q, cnt_d;
  logic grant_valid, grant_sel, busy, timeout, done;
  mem_arb_pick #(.D_PRIORITY(D_PRIORITY)) u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .rr_last    (rr_last_q),
    .grant_valid(grant_valid),
    .grant_sel  (grant_sel)
  );
  assign busy    = state_q == ST_BUSY;
  assign timeout = busy & ~ram_ack & (cnt_q == CW'(TIMEOUT - 1));
  assign done    = busy & (ram_ack | timeout);
  // cs drops in the ack/timeout cycle so the RAM never sees a fresh access start
  assign ram_cs   = busy & ~ram_ack & ~timeout;
  assign ram_we   = we_q;
  assign ram_addr = addr_q;
  assign ram_din  = din_q;
  assign rdata    = (ram_ack & ~we_q) ? ram_dout : '0;
  assign d_ack    = done & (sel_q == SEL_D);
  assign i_ack    = done & (sel_q == SEL_I);
  assign d_err    = timeout & (sel_q == SEL_D);
  assign i_err    = timeout & (sel_q == SEL_I);
  assign d_rdata  = d_ack ? rdata : '0;
  assign i_rdata  = i_ack ? rdata : '0;
  assign d_stall  = d_req & ~d_ack;
  assign i_stall  = i_req & ~i_ack;
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    rr_last_d = rr_last_q;
    we_d      = we_q;
    addr_d    = addr_q;
    din_d     = din_q;
    cnt_d     = cnt_q;
    if (state_q == ST_IDLE && grant_valid) begin
      sel_d   = grant_sel;
      we_d    = (grant_sel == SEL_D) & d_we;
      addr_d  = (grant_sel == SEL_D) ? d_addr : i_addr;
      din_d   = (grant_sel == SEL_D) ? d_wdata : '0;
      cnt_d   = '0;
      state_d = ST_BUSY;
    end
    if (busy) begin
      cnt_d     = done ? cnt_q : cnt_q + CW'(1);
      rr_last_d = done ? sel_q : rr_last_q;
      state_d   = ram_ack ? ST_IDLE : (timeout ? ST_RECOVER : ST_BUSY);
    end
    if (state_q == ST_RECOVER) state_d = ST_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sel_q     <= SEL_D;
      rr_last_q <= SEL_I;
      we_q      <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      rr_last_q <= rr_last_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      cnt_q     <= cnt_d;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of two arbiter instances (D-priority/TIMEOUT=8 and round-robin/TIMEOUT=16)
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic [1:0] rst, i_req, i_ack, i_err, i_stall, d_req, d_we, d_ack, d_err, d_stall;
  logic [1:0] ram_cs, ram_we, ram_ack, mute, force_ack;
  logic [31:0] i_addr [2], i_rdata [2], d_addr [2], d_wdata [2], d_rdata [2];
  logic [31:0] ram_addr [2], ram_din [2], ram_dout [2];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;

  typedef struct {
    logic d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic cs, ack;
    logic [31:0] rdata;
  } vec_t;
  vec_t tbl[$];

  for (genvar g = 0; g < 2; g++) begin : g_u
    logic [31:0] mem [64];
    logic [31:0] dout;
    logic [2:0] rc;
    logic ack_q;
    initial for (int k = 0; k < 64; k++) mem[k] = (k == 4) ? 32'hCAFEBABE : (32'hA5000000 | k);
    // four-cycle slave: ack in the cycle after cs has been seen high four times
    always @(posedge clk) begin
      if (rst[g]) begin
        rc <= 3'd0;
        ack_q <= 1'b0;
      end else begin
        ack_q <= 1'b0;
        if (ram_cs[g] && !mute[g]) begin
          if (rc == 3'd3) begin
            ack_q <= 1'b1;
            rc <= 3'd0;
            dout <= mem[ram_addr[g][7:2]];
            if (ram_we[g]) mem[ram_addr[g][7:2]] <= ram_din[g];
          end else rc <= rc + 3'd1;
        end else if (!ram_cs[g]) rc <= 3'd0;
      end
    end
    assign ram_ack[g]  = ack_q | force_ack[g];
    assign ram_dout[g] = dout;
    mem_arbiter #(.DATA_WIDTH(32), .TIMEOUT(g == 0 ? 8 : 16), .D_PRIORITY(g == 0 ? 1 : 0)) u_dut (
      .clk(clk), .rst(rst[g]),
      .i_req(i_req[g]), .i_addr(i_addr[g]), .i_rdata(i_rdata[g]), .i_ack(i_ack[g]),
      .i_err(i_err[g]), .i_stall(i_stall[g]),
      .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
      .d_rdata(d_rdata[g]), .d_ack(d_ack[g]), .d_err(d_err[g]), .d_stall(d_stall[g]),
      .ram_cs(ram_cs[g]), .ram_we(ram_we[g]), .ram_addr(ram_addr[g]), .ram_din(ram_din[g]),
      .ram_dout(ram_dout[g]), .ram_ack(ram_ack[g])
    );
  end

  task automatic step(input int u, input string nm, input logic cs, input logic da, input logic de,
                      input logic [31:0] dr, input logic ia, input logic [31:0] ir);
    logic [70:0] got, exp;
    @(negedge clk);
    exp = {cs, da, de, d_req[u] & ~da, ia, 1'b0, i_req[u] & ~ia, dr, ir};
    got = {ram_cs[u], d_ack[u], d_err[u], d_stall[u], i_ack[u], i_err[u], i_stall[u], d_rdata[u], i_rdata[u]};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s u%0d t=%0t {cs,dack,derr,dstall,iack,ierr,istall,drdata,irdata} got=%h exp=%h",
               nm, u, $time, got, exp);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 2'b11; i_req = '0; d_req = '0; d_we = '0; mute = '0; force_ack = '0;
    for (int u = 0; u < 2; u++) begin
      i_addr[u] = '0; d_addr[u] = '0; d_wdata[u] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = '0;
    step(0, "reset", 0, 0, 0, 0, 0, 0);
    step(1, "reset", 0, 0, 0, 0, 0, 0);

    // D read, then D write (address/data scrambled after grant), then D read back
    tbl.push_back('{1, 0, 32'h10, 0, 0, 0, 0});
    repeat (4) tbl.push_back('{1, 0, 32'h10, 0, 1, 0, 0});
    tbl.push_back('{1, 0, 32'h10, 0, 0, 1, 32'hCAFEBABE});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 1, 32'h20, 32'h12345678, 0, 0, 0});
    repeat (4) tbl.push_back('{1, 1, 32'h3C, 32'hDEADBEEF, 1, 0, 0});
    tbl.push_back('{1, 1, 32'h3C, 32'hDEADBEEF, 0, 1, 0});
    tbl.push_back('{1, 0, 32'h20, 0, 0, 0, 0});
    repeat (4) tbl.push_back('{1, 0, 32'h20, 0, 1, 0, 0});
    tbl.push_back('{1, 0, 32'h20, 0, 0, 1, 32'h12345678});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0});
    foreach (tbl[n]) begin
      d_req[0] = tbl[n].d_req; d_we[0] = tbl[n].d_we;
      d_addr[0] = tbl[n].d_addr; d_wdata[0] = tbl[n].d_wdata;
      step(0, "table", tbl[n].cs, tbl[n].ack, 1'b0, tbl[n].rdata, 1'b0, 32'h0);
    end
    d_we[0] = 1'b0;

    // simultaneous requests with D priority
    d_addr[0] = 32'h10; i_addr[0] = 32'h14;
    for (int c = 0; c <= 12; c++) begin
      d_req[0] = (c <= 5); i_req[0] = (c <= 11);
      step(0, "tie_dprio", (c >= 1 && c <= 4) || (c >= 7 && c <= 10), c == 5, 1'b0,
           (c == 5) ? 32'hCAFEBABE : 32'h0, c == 11, (c == 11) ? 32'hA5000005 : 32'h0);
    end

    // round-robin with both masters held continuously
    d_addr[1] = 32'h10; i_addr[1] = 32'h14;
    for (int c = 0; c <= 24; c++) begin
      d_req[1] = (c <= 23); i_req[1] = (c <= 23);
      step(1, "round_robin", (c < 24) && (c % 6 >= 1) && (c % 6 <= 4), c == 5 || c == 17, 1'b0,
           (c == 5 || c == 17) ? 32'hCAFEBABE : 32'h0, c == 11 || c == 23,
           (c == 11 || c == 23) ? 32'hA5000005 : 32'h0);
    end

    // watchdog timeout, late ack in RECOVER, then a normal access
    for (int c = 0; c <= 16; c++) begin
      d_req[0] = (c <= 15); mute[0] = (c <= 9); force_ack[0] = (c == 9);
      step(0, "timeout", (c >= 1 && c <= 7) || (c >= 11 && c <= 14), c == 8 || c == 15, c == 8,
           (c == 15) ? 32'hCAFEBABE : 32'h0, 1'b0, 32'h0);
    end
    force_ack[0] = 1'b0; mute[0] = 1'b0;

    // reset in the middle of an access
    for (int c = 0; c <= 13; c++) begin
      rst[0] = (c == 3);
      d_req[0] = (c <= 2) || (c >= 7 && c <= 12);
      step(0, "mid_rst", (c >= 1 && c <= 3) || (c >= 8 && c <= 11), c == 12, 1'b0,
           (c == 12) ? 32'hCAFEBABE : 32'h0, 1'b0, 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
